// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared widths, FSM state and response entry type for the instruction memory responder
package imem_responder_pkg;
  localparam int ADDR_LINE = 32;
  localparam int D_SIZE = 32;
  localparam int INST_W = D_SIZE;
  typedef enum logic {LOAD, RUN} state_t;
  typedef struct packed {
    logic [ADDR_LINE-1:0] addr;
    logic [INST_W-1:0] data;
    logic err;
  } imem_rsp_t;
endpackage

// File: rtl/imem_responder_resp_fifo.sv
// imem_responder_resp_fifo: synchronous FIFO of response entries with flush that keeps a same-cycle push
module imem_responder_resp_fifo
  import imem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  imem_rsp_t din,
  input  logic      pop,
  output imem_rsp_t dout,
  output logic      empty,
  output logic      full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  imem_rsp_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop, wr_en;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_en = !rst && (flush ? push : do_push);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= push ? inc(PW'(0)) : '0;
      cnt <= CW'(push);
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  // a push during flush lands at slot 0 so it survives as the new head
  always_ff @(posedge clk) begin
    if (wr_en) mem[flush ? PW'(0) : wr] <= din;
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: preloadable instruction memory answering fetch requests after a fixed latency through a response queue
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int LAT = 2,
  parameter int Q_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INST_W-1:0]        load_data,
  input  logic                     load_done,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     rsp_valid,
  output logic [INST_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_err,
  input  logic                     rsp_ready
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(Q_DEPTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [INST_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic acc_err, accept, pop, push, empty, full;
  imem_rsp_t acc_e, push_e, head;
  assign idx = req_addr[ADDR_W-1:2];
  assign acc_err = |req_addr[1:0] || idx >= (ADDR_W-2)'(DEPTH);
  assign acc_e = '{addr: ADDR_LINE'(req_addr), data: acc_err ? INST_W'(0) : mem[idx[IW-1:0]], err: acc_err};
  // count covers pipeline plus queue, so it alone bounds the queue; full is a redundant guard
  assign req_ready = state == RUN && !load_en && count < CW'(Q_DEPTH) && !full;
  assign accept = req_valid && req_ready;
  assign pop = rsp_valid && rsp_ready;
  assign state_nx = (state == LOAD && load_done) ? RUN : state;
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else count <= flush ? CW'(accept) : count + CW'(accept) - CW'(pop);
  end
  // the last delay stage feeds the queue directly, so the registered stages number LAT-1
  if (LAT == 1) begin : g_direct
    assign push = accept;
    assign push_e = acc_e;
  end else begin : g_pipe
    logic dv [LAT-1];
    imem_rsp_t de [LAT-1];
    always_ff @(posedge clk) begin
      dv[0] <= !reset && accept;
      de[0] <= acc_e;
      for (int i = 1; i < LAT - 1; i++) begin
        dv[i] <= !reset && !flush && dv[i-1];
        de[i] <= de[i-1];
      end
    end
    assign push = dv[LAT-2] && !flush;
    assign push_e = de[LAT-2];
  end
  imem_responder_resp_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(flush),
    .push(push),
    .din(push_e),
    .pop(pop),
    .dout(head),
    .empty(empty),
    .full(full)
  );
  assign rsp_valid = !empty;
  assign rsp_data = empty ? '0 : head.data;
  assign rsp_addr = empty ? '0 : ADDR_W'(head.addr);
  assign rsp_err = !empty && head.err;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: vector table, directed corner sequences and random traffic checked against a timestamped queue model
module tb_imem_responder;
  localparam int LAT = 2;
  localparam int QD = 4;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic reset, load_en, load_done, req_valid, req_ready, flush, rsp_valid, rsp_err, rsp_ready;
  logic [9:0] load_addr;
  logic [31:0] load_data, req_addr, rsp_data, rsp_addr;
  always #5 clk = ~clk;
  imem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LAT(LAT), .Q_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic err;
    int avail;
  } ent_t;
  typedef struct {
    logic le;
    logic [9:0] la;
    logic [31:0] ld;
    logic rv;
    logic [31:0] ra;
    logic rr;
    logic x_ready;
    logic x_valid;
    logic [31:0] x_data;
    logic x_err;
  } vec_t;
  int n_vec = 0, n_err = 0, cyc = 0;
  ent_t q[$];
  logic [31:0] mm [DEPTH];
  bit m_run = 0;
  logic s_ready, s_valid, s_err;
  logic [31:0] s_data, s_addr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // one clock: drive, sample at negedge, compare with the model, then advance the model at the edge
  task automatic step(input logic le, input logic [9:0] la, input logic [31:0] ld, input logic done,
                      input logic rv, input logic [31:0] ra, input logic fl, input logic rr, input logic rs);
    bit er, ev, acc, pp;
    ent_t e;
    load_en = le; load_addr = la; load_data = ld; load_done = done;
    req_valid = rv; req_addr = ra; flush = fl; rsp_ready = rr; reset = rs;
    @(negedge clk);
    s_ready = req_ready; s_valid = rsp_valid; s_data = rsp_data; s_addr = rsp_addr; s_err = rsp_err;
    er = m_run && !le && q.size() < QD;
    ev = q.size() > 0 && q[0].avail <= cyc;
    chk("req_ready", 32'(s_ready), 32'(er));
    chk("rsp_valid", 32'(s_valid), 32'(ev));
    if (ev) begin
      chk("rsp_data", s_data, q[0].data);
      chk("rsp_addr", s_addr, q[0].addr);
      chk("rsp_err", 32'(s_err), 32'(q[0].err));
    end
    acc = er && rv;
    pp = ev && rr;
    e.addr = ra;
    e.err = ra[1:0] != 2'b00 || ra[31:2] >= 30'(DEPTH);
    e.data = e.err ? 32'h0 : mm[ra[11:2]];
    e.avail = cyc + LAT;
    @(posedge clk);
    if (le) mm[la] = ld;
    if (rs) begin
      q.delete();
      m_run = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (fl) q.delete();
      if (acc) q.push_back(e);
      if (done) m_run = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, rr, 1'b0);
  endtask

  task automatic req(input logic [31:0] ra, input logic fl, input logic rr);
    step(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, ra, fl, rr, 1'b0);
  endtask

  initial begin
    vec_t tv[10];
    logic [31:0] prog[4];
    int a[5];
    logic [31:0] got[$];
    int k;
    prog = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
    a = '{0, 4, 8, 12, 16};
    tv[0] = '{1'b0, 10'd0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[1] = '{1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[2] = '{1'b0, 10'd0, 32'h0, 1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h20080005, 1'b0};
    tv[3] = '{1'b0, 10'd0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[4] = '{1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1};
    tv[5] = '{1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1};
    tv[6] = '{1'b1, 10'd5, 32'h12345678, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    tv[7] = '{1'b0, 10'd0, 32'h0, 1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[8] = '{1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    tv[9] = '{1'b0, 10'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0};
    reset = 1; load_en = 0; load_addr = 0; load_data = 0; load_done = 0;
    req_valid = 0; req_addr = 0; flush = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(1'b0);
    chk("reset_rsp_data", s_data, 32'h0);
    chk("reset_rsp_addr", s_addr, 32'h0);
    chk("reset_rsp_err", 32'(s_err), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 10'(i), i < 4 ? prog[i] : $urandom, 1'b0, i % 7 == 0, 32'(i * 4), 1'b0, 1'b1, 1'b0);
      chk("load_ready", 32'(s_ready), 32'h0);
    end
    step(1'b0, 10'd0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("load_done_ready", 32'(s_ready), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(tv[i].le, tv[i].la, tv[i].ld, 1'b0, tv[i].rv, tv[i].ra, 1'b0, tv[i].rr, 1'b0);
      chk($sformatf("tv%0d_ready", i), 32'(s_ready), 32'(tv[i].x_ready));
      chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].x_valid));
      if (tv[i].x_valid) begin
        chk($sformatf("tv%0d_data", i), s_data, tv[i].x_data);
        chk($sformatf("tv%0d_err", i), 32'(s_err), 32'(tv[i].x_err));
      end
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      req(32'(a[k]), 1'b0, 1'b0);
      if (s_ready) k++;
    end
    chk("bp_accepts", 32'(k), 32'd4);
    chk("bp_held", 32'(s_ready), 32'h0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 10'd0, 32'h0, 1'b0, k < 5, 32'(a[k < 5 ? k : 0]), 1'b0, 1'b1, 1'b0);
      if (s_ready && k < 5) k++;
      if (s_valid) got.push_back(s_addr);
    end
    chk("bp_all_accepted", 32'(k), 32'd5);
    chk("bp_rsp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("bp_order%0d", i), got[i], 32'(a[i]));
    got.delete();
    req(32'h0, 1'b0, 1'b0);
    req(32'h4, 1'b0, 1'b0);
    req(32'h8, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      idle(1'b1);
      if (s_valid) got.push_back(s_data);
    end
    chk("flush_rsp_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("flush_rsp_data", got[0], 32'h01095020);
    chk("flush_ready_after", 32'(s_ready), 32'h1);
    req(32'h0, 1'b0, 1'b0);
    req(32'h4, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("rst_queued_valid", 32'(s_valid), 32'h1);
    step(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    step(1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    req(32'h4, 1'b0, 1'b1);
    chk("rst_run_ready", 32'(s_ready), 32'h1);
    idle(1'b1);
    idle(1'b1);
    chk("rst_img_valid", 32'(s_valid), 32'h1);
    chk("rst_img_data", s_data, 32'h20090003);
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] ra;
      r = $urandom_range(0, 9);
      ra = r < 7 ? {20'h0, 10'($urandom_range(0, 1023)), 2'b00} :
           r == 7 ? {18'h0, 12'($urandom_range(0, 4200)), 2'($urandom_range(1, 3))} :
           (r == 8 ? {20'h0, 12'($urandom_range(4096, 4127))} & 32'hFFFF_FFFC : $urandom);
      step($urandom_range(0, 19) == 0, 10'($urandom_range(0, 1023)), $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, ra,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
